instr_fetch_unit: RTL and testbench

Fetch-side counterpart of the program-counter register. It accepts the current PC from the PC register and converts the byte address, based at the text segment (0x0040_0000), into an instruction-memory word index. It then runs a request/acknowledge read to instruction memory and presents the fetched instruction to the decode stage with a valid/ready handshake. Misaligned addresses, out-of-range addresses and memory timeouts are reported as sticky faults.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch unit: turns a text-segment byte PC into an instruction-memory word index,
// runs a req/ack memory read and hands the instruction to decode via valid/ready.
module instr_fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fetch_start,
  input  logic [31:0]           i_pc_in,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [31:0]           o_instr_pc,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  output logic                  o_busy,
  output logic                  o_fault,
  output logic [1:0]            o_fault_code,
  input  logic                  i_fault_clr
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [31:0]           r_instr_pc;
  logic                  r_instr_valid;
  logic                  r_busy;
  logic                  r_fault;
  logic [1:0]            r_fault_code;
  logic [31:0]           r_held_pc;
  logic [7:0]            r_cnt;

  logic                  w_launch;
  logic [1:0]            w_pc_code;
  logic [ADDR_WIDTH-1:0] w_pc_idx;

  // Misalignment has priority over range; the range test uses the full 32-bit offset.
  function automatic logic [1:0] pc_fault(input logic [31:0] pc);
    logic [31:0] d;
    d = pc - TEXT_BASE;
    if (pc[1:0] != 2'b00) return FC_MISALIGN;
    if ((pc < TEXT_BASE) || ((d >> (ADDR_WIDTH + 2)) != 32'd0)) return FC_RANGE;
    return FC_NONE;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] pc);
    logic [31:0] d;
    d = pc - TEXT_BASE;
    return d[ADDR_WIDTH+1:2];
  endfunction

  assign w_pc_code = pc_fault(i_pc_in);
  assign w_pc_idx  = word_index(i_pc_in);
  assign w_launch  = i_fetch_start &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_instr_ready));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= TEXT_BASE;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_held_pc     <= TEXT_BASE;
      r_cnt         <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_REQ: begin
          // An ack on the timeout cycle still wins.
          if (i_mem_ack) begin
            r_instr       <= i_mem_rdata;
            r_instr_pc    <= r_held_pc;
            r_instr_valid <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= S_HOLD;
          end else if (r_cnt == 8'(TIMEOUT)) begin
            r_mem_req    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_TIMEOUT;
            r_state      <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (i_instr_ready) begin
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (i_fault_clr) begin
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Acceptance from IDLE or a back-to-back handoff from HOLD overrides the above.
      if (w_launch) begin
        r_busy <= 1'b1;
        if (w_pc_code != FC_NONE) begin
          r_fault      <= 1'b1;
          r_fault_code <= w_pc_code;
          r_state      <= S_FAULT;
        end else begin
          r_held_pc  <= i_pc_in;
          r_mem_addr <= w_pc_idx;
          r_mem_req  <= 1'b1;
          r_cnt      <= 8'd0;
          r_state    <= S_REQ;
        end
      end
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_busy        = r_busy;
  assign o_fault       = r_fault;
  assign o_fault_code  = r_fault_code;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table vectors, hand-written corner sequences and
// randomized fetches checked against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int          AW      = 10;
  localparam logic [31:0] BASE    = 32'h0040_0000;
  localparam int          TMO     = 15;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, fetch_start, mem_ack, instr_ready, fault_clr;
  logic [31:0]   pc_in, mem_rdata;
  logic          mem_req, instr_valid, busy, fault;
  logic [AW-1:0] mem_addr;
  logic [31:0]   instr, instr_pc;
  logic [1:0]    fault_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .TEXT_BASE(BASE), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_start(fetch_start), .i_pc_in(pc_in),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_instr(instr), .o_instr_pc(instr_pc), .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready), .o_busy(busy), .o_fault(fault), .o_fault_code(fault_code),
    .i_fault_clr(fault_clr)
  );

  typedef struct {
    logic [31:0] pc;
    int          ack_dly;
    logic [31:0] rdata;
    int          rdy_dly;
    logic [1:0]  code;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: address classification from the plain arithmetic rules.
  function automatic void model(input logic [31:0] pc, output logic [1:0] code,
                                output logic [31:0] idx);
    longint unsigned off;
    idx  = 32'd0;
    if (pc % 4 != 0) code = 2'b01;
    else if (pc < BASE) code = 2'b10;
    else begin
      off = longint'(pc) - longint'(BASE);
      if (off / 4 >= (64'd1 << AW)) code = 2'b10;
      else begin
        code = 2'b00;
        idx  = 32'(off / 4);
      end
    end
  endfunction

  // One complete transaction starting from IDLE and ending back in IDLE.
  task automatic run_txn(input logic [31:0] pc, input int ack_dly, input logic [31:0] rdata,
                         input int rdy_dly, input logic [1:0] code, input logic [31:0] addr);
    int req_cycles;
    logic [31:0] held;
    pc_in = pc; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    if (code != 2'b00) begin
      check("addr_fault", {31'd0, fault}, 32'd1);
      check("addr_fault_code", {30'd0, fault_code}, {30'd0, code});
      check("addr_fault_no_req", {31'd0, mem_req}, 32'd0);
      pc_in = BASE; fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("fault_ignores_start", {29'd0, mem_req, fault_code}, {29'd0, 1'b0, code});
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("fault_clr", {30'd0, fault, busy}, 32'd0);
      return;
    end
    check("req_after_accept", {31'd0, mem_req}, 32'd1);
    check("mem_addr", 32'(mem_addr), addr);
    check("no_valid_at_accept", {31'd0, instr_valid}, 32'd0);
    if (ack_dly > TMO) begin
      req_cycles = 1;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (mem_req) req_cycles++;
        else break;
      end
      check("timeout_req_cycles", req_cycles, TMO + 1);
      check("timeout_code", {29'd0, fault, fault_code}, 32'b111);
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      check("late_ack_no_valid", {31'd0, instr_valid}, 32'd0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("timeout_clr", {29'd0, fault, busy, mem_req}, 32'd0);
      return;
    end
    repeat (ack_dly) tick();
    check("req_held", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    check("instr_valid", {30'd0, instr_valid, mem_req}, 32'b10);
    check("instr", instr, rdata);
    check("instr_pc", instr_pc, pc);
    held = instr;
    for (int k = 0; k < rdy_dly; k++) begin
      tick();
      check("hold_stable", {instr[31:1], instr_valid}, {held[31:1], 1'b1});
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("after_ready", {30'd0, instr_valid, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mcode;
    logic [31:0] midx, pc;
    int sel;

    tbl[0] = '{32'h0040_0000, 0,  32'h0050_0093, 0, 2'b00, 32'd0};
    tbl[1] = '{32'h0040_0FFC, 2,  32'hDEAD_BEEF, 1, 2'b00, 32'd1023};
    tbl[2] = '{32'h0040_1000, 0,  32'h0,         0, 2'b10, 32'd0};
    tbl[3] = '{32'h003F_FFFC, 0,  32'h0,         0, 2'b10, 32'd0};
    tbl[4] = '{32'h0040_0006, 0,  32'h0,         0, 2'b01, 32'd0};
    tbl[5] = '{32'h0040_0010, 20, 32'h1234_5678, 0, 2'b00, 32'd4};
    tbl[6] = '{32'h0040_0008, 15, 32'hCAFE_F00D, 5, 2'b00, 32'd2};

    rst = 1'b1; fetch_start = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; fault_clr = 1'b0;
    pc_in = 32'd0; mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, BASE);
    check("rst_ctrl", {26'd0, mem_req, instr_valid, busy, fault, fault_code}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].pc, tbl[i].ack_dly, tbl[i].rdata, tbl[i].rdy_dly, tbl[i].code, tbl[i].addr);

    // Back-to-back: ready and fetch_start together in HOLD.
    pc_in = BASE; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 1'b0;
    repeat (5) tick();
    check("b2b_hold", instr, 32'hAAAA_5555);
    instr_ready = 1'b1; fetch_start = 1'b1; pc_in = 32'h0040_0004;
    tick();
    instr_ready = 1'b0; fetch_start = 1'b0;
    check("b2b_req", {30'd0, mem_req, instr_valid}, 32'b10);
    check("b2b_addr", 32'(mem_addr), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    check("b2b_instr_pc", instr_pc, 32'h0040_0004);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Reset during REQ discards a same-cycle ack.
    pc_in = 32'h0040_0020; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    check("rst_req_ctrl", {29'd0, mem_req, instr_valid, busy}, 32'd0);
    check("rst_req_instr", instr, NOP);
    check("rst_req_instr_pc", instr_pc, BASE);
    tick();
    check("rst_req_no_output", {31'd0, instr_valid}, 32'd0);

    // Randomized fetches against the model.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: pc = BASE + ($urandom_range(0, 4095) & ~32'd3) + $urandom_range(1, 3);
        1: pc = $urandom_range(0, 32'h003F_FFFF);
        2: pc = BASE + 32'd4096 + ($urandom_range(0, 1 << 20) << 2);
        default: pc = BASE + ($urandom_range(0, 1023) << 2);
      endcase
      model(pc, mcode, midx);
      run_txn(pc, $urandom_range(0, 18), $urandom, $urandom_range(0, 3), mcode, midx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
